mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit between the EX stage and the MEM/WB pipeline register. It registers EX results and drives a req/ack data-memory port for loads and stores. It aligns and extends load data and stalls upstream while an access is outstanding. Its outputs MEM_ALU_RES, MEM_DM_Q and MEM_RF_D_SEL connect directly to the MEM/WB register; MEM_VALID marks bubbles.

Parameters:
TIMEOUT_CYCLES, 16, ACCESS cycles without DM_ACK before abort (only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
EX_VALID  in  1  EX stage holds a valid instruction
EX_ALU_RES  in  32  ALU result, also the load/store byte address
EX_RS2_DATA  in  32  store data
EX_MEM_RD  in  1  load
EX_MEM_WR  in  1  store; RD and WR never both 1
EX_MEM_SIZE  in  2  00 byte, 01 half, 10/11 word
EX_MEM_UNSIGNED  in  1  zero-extend loads when 1, sign-extend when 0
EX_RF_D_SEL  in  2  writeback source select, passed through
DM_REQ  out  1  memory request
DM_WE  out  1  1 = write
DM_ADDR  out  32  word address, {EX_ALU_RES[31:2],2'b00}
DM_WDATA  out  32  lane-replicated store data
DM_BE  out  4  byte enables
DM_RDATA  in  32  read data, valid with DM_ACK
DM_ACK  in  1  access complete
MEM_ALU_RES  out  32  registered ALU result
MEM_DM_Q  out  32  aligned, extended load data
MEM_RF_D_SEL  out  2  registered writeback select
MEM_VALID  out  1  outputs carry a completed instruction this cycle
MEM_MISALIGN  out  1  misaligned access flagged, qualified by MEM_VALID
MEM_BUS_ERR  out  1  access timed out, qualified by MEM_VALID
MEM_STALL  out  1  combinational; upstream must hold EX_* while 1

Behaviour:
- Reset (async, rst_n=0): state IDLE; all registered outputs 0; DM_REQ drops immediately. Reset during ACCESS abandons the transaction.
- States: IDLE, ACCESS. MEM_STALL = (state==ACCESS).
- IDLE, EX_VALID=0: MEM_VALID<=0; MEM_MISALIGN<=0; MEM_BUS_ERR<=0; data outputs hold.
- IDLE, EX_VALID=1, no memory op: latch ALU_RES and RF_D_SEL; MEM_DM_Q<=0; MEM_VALID<=1. Latency 1 cycle.
- IDLE, memory op, misaligned: half with addr[0]=1, or word with addr[1:0]!=0. No request is issued. MEM_MISALIGN<=1; MEM_DM_Q<=0; MEM_VALID<=1.
- IDLE, memory op, aligned: latch all fields; DM_REQ<=1; DM_WE<=EX_MEM_WR; drive DM_ADDR, DM_BE and DM_WDATA; MEM_VALID<=0; go to ACCESS.
- ACCESS: DM_REQ, DM_ADDR, DM_BE, DM_WDATA and DM_WE held stable until DM_ACK is sampled 1. On ack: DM_REQ<=0; for a load, MEM_DM_Q<=aligned data (store: 0); MEM_VALID<=1; go to IDLE.
- Minimum memory-op latency: 2 cycles (ack in the first ACCESS cycle).
- DM_ACK in IDLE is ignored. Back-to-back memory ops: the next request issues the cycle after return to IDLE.
- Byte enables: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
- Store data: byte = {4{rs2[7:0]}}; half = {2{rs2[15:0]}}; word = rs2.
- Load extract: byte lane addr[1:0]; half lane addr[1]. Extend to 32 bits by EX_MEM_UNSIGNED.
- Error flags clear on the next registered update.

Optional Feature:
LSU_TIMEOUT_EN defined:
- A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments on each ACCESS cycle without ack.
- When the count reaches TIMEOUT_CYCLES with no ack: DM_REQ<=0; MEM_BUS_ERR<=1; MEM_DM_Q<=0; MEM_VALID<=1; go to IDLE.
- An ack in the same cycle as the limit wins: normal completion, no error.
LSU_TIMEOUT_EN undefined: no counter; MEM_BUS_ERR tied 0; ACCESS waits indefinitely.

Test Plan:
- ALU op: EX_ALU_RES=0x12345678, RF_D_SEL=01, EX_VALID=1 -> next cycle MEM_ALU_RES=0x12345678, MEM_RF_D_SEL=01, MEM_VALID=1, DM_REQ=0.
- Signed byte load: addr 0x103, DM_RDATA=0x80FFFFFF, ack after 3 cycles -> DM_ADDR=0x100, DM_BE=1000, MEM_STALL=1 for 3 cycles, then MEM_DM_Q=0xFFFFFF80, MEM_VALID=1 for one cycle.
- Half store: addr 0x22, rs2=0xAAAABEEF -> DM_WE=1, DM_BE=1100, DM_WDATA=0xBEEFBEEF, held until ack.
- Misaligned word load: addr 0x41 -> no DM_REQ, MEM_MISALIGN=1, MEM_VALID=1 after 1 cycle.
- rst_n low mid-ACCESS -> DM_REQ=0 and MEM_STALL=0 immediately; all outputs 0; after release, a new load completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> DM_REQ drops after 4 ACCESS cycles, MEM_BUS_ERR=1, MEM_VALID=1; ack asserted on the 4th cycle -> normal completion, MEM_BUS_ERR=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: req/ack data port, load align/extend, upstream stall
// Optional access timeout: define LSU_TIMEOUT_EN.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_VALID,
    input  logic [31:0] EX_ALU_RES,
    input  logic [31:0] EX_RS2_DATA,
    input  logic        EX_MEM_RD,
    input  logic        EX_MEM_WR,
    input  logic [1:0]  EX_MEM_SIZE,
    input  logic        EX_MEM_UNSIGNED,
    input  logic [1:0]  EX_RF_D_SEL,
    output logic        DM_REQ,
    output logic        DM_WE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WDATA,
    output logic [3:0]  DM_BE,
    input  logic [31:0] DM_RDATA,
    input  logic        DM_ACK,
    output logic [31:0] MEM_ALU_RES,
    output logic [31:0] MEM_DM_Q,
    output logic [1:0]  MEM_RF_D_SEL,
    output logic        MEM_VALID,
    output logic        MEM_MISALIGN,
    output logic        MEM_BUS_ERR,
    output logic        MEM_STALL
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] alu_res_q, alu_res_d;
    logic [31:0] dm_q_q, dm_q_d;
    logic [1:0]  rf_d_sel_q, rf_d_sel_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic        is_load_q, is_load_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_uns_q, ld_uns_d;
    logic [1:0]  ld_off_q, ld_off_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    logic [1:0]  ex_off;
    logic        ex_is_mem;
    logic        ex_misaligned;
    logic [3:0]  ex_be;
    logic [31:0] ex_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ex_off        = EX_ALU_RES[1:0];
        ex_is_mem     = EX_MEM_RD | EX_MEM_WR;
        ex_misaligned = ((EX_MEM_SIZE == 2'b01) && ex_off[0]) ||
                        (EX_MEM_SIZE[1] && (ex_off != 2'b00));
        case (EX_MEM_SIZE)
            2'b00:   ex_be = 4'b0001 << ex_off;
            2'b01:   ex_be = ex_off[1] ? 4'b1100 : 4'b0011;
            default: ex_be = 4'b1111;
        endcase
        case (EX_MEM_SIZE)
            2'b00:   ex_wdata = {4{EX_RS2_DATA[7:0]}};
            2'b01:   ex_wdata = {2{EX_RS2_DATA[15:0]}};
            default: ex_wdata = EX_RS2_DATA;
        endcase
    end

    // Lane selection uses the offset captured at issue, not the live EX address.
    always_comb begin
        case (ld_off_q)
            2'b00:   ld_byte = DM_RDATA[7:0];
            2'b01:   ld_byte = DM_RDATA[15:8];
            2'b10:   ld_byte = DM_RDATA[23:16];
            default: ld_byte = DM_RDATA[31:24];
        endcase
        ld_half = ld_off_q[1] ? DM_RDATA[31:16] : DM_RDATA[15:0];
        case (ld_size_q)
            2'b00:   ld_data = ld_uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = ld_uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = DM_RDATA;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_be_d    = dm_be_q;
        alu_res_d  = alu_res_q;
        dm_q_d     = dm_q_q;
        rf_d_sel_d = rf_d_sel_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        is_load_d  = is_load_q;
        ld_size_d  = ld_size_q;
        ld_uns_d   = ld_uns_q;
        ld_off_d   = ld_off_q;
`ifdef LSU_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        bus_err_d  = bus_err_q;
`endif
        case (state_q)
            IDLE: begin
                valid_d    = 1'b0;
                misalign_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
                bus_err_d  = 1'b0;
`endif
                if (EX_VALID) begin
                    alu_res_d  = EX_ALU_RES;
                    rf_d_sel_d = EX_RF_D_SEL;
                    dm_q_d     = 32'h0;
                    if (!ex_is_mem) begin
                        valid_d = 1'b1;
                    end else if (ex_misaligned) begin
                        misalign_d = 1'b1;
                        valid_d    = 1'b1;
                    end else begin
                        dm_req_d   = 1'b1;
                        dm_we_d    = EX_MEM_WR;
                        dm_addr_d  = {EX_ALU_RES[31:2], 2'b00};
                        dm_be_d    = ex_be;
                        dm_wdata_d = ex_wdata;
                        is_load_d  = EX_MEM_RD;
                        ld_size_d  = EX_MEM_SIZE;
                        ld_uns_d   = EX_MEM_UNSIGNED;
                        ld_off_d   = ex_off;
                        state_d    = ACCESS;
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt_d  = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                if (DM_ACK) begin
                    dm_req_d = 1'b0;
                    dm_q_d   = is_load_q ? ld_data : 32'h0;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
`ifdef LSU_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    dm_req_d  = 1'b0;
                    bus_err_d = 1'b1;
                    dm_q_d    = 32'h0;
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 32'h0;
            dm_wdata_q <= 32'h0;
            dm_be_q    <= 4'h0;
            alu_res_q  <= 32'h0;
            dm_q_q     <= 32'h0;
            rf_d_sel_q <= 2'b00;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            is_load_q  <= 1'b0;
            ld_size_q  <= 2'b00;
            ld_uns_q   <= 1'b0;
            ld_off_q   <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_be_q    <= dm_be_d;
            alu_res_q  <= alu_res_d;
            dm_q_q     <= dm_q_d;
            rf_d_sel_q <= rf_d_sel_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            is_load_q  <= is_load_d;
            ld_size_q  <= ld_size_d;
            ld_uns_q   <= ld_uns_d;
            ld_off_q   <= ld_off_d;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    assign DM_REQ       = dm_req_q;
    assign DM_WE        = dm_we_q;
    assign DM_ADDR      = dm_addr_q;
    assign DM_WDATA     = dm_wdata_q;
    assign DM_BE        = dm_be_q;
    assign MEM_ALU_RES  = alu_res_q;
    assign MEM_DM_Q     = dm_q_q;
    assign MEM_RF_D_SEL = rf_d_sel_q;
    assign MEM_VALID    = valid_q;
    assign MEM_MISALIGN = misalign_q;
    assign MEM_STALL    = (state_q == ACCESS);
`ifdef LSU_TIMEOUT_EN
    assign MEM_BUS_ERR  = bus_err_q;
`else
    assign MEM_BUS_ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu with a req/ack memory responder
module tb_mem_stage_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EX_VALID;
    logic [31:0] EX_ALU_RES;
    logic [31:0] EX_RS2_DATA;
    logic        EX_MEM_RD;
    logic        EX_MEM_WR;
    logic [1:0]  EX_MEM_SIZE;
    logic        EX_MEM_UNSIGNED;
    logic [1:0]  EX_RF_D_SEL;
    logic        DM_REQ;
    logic        DM_WE;
    logic [31:0] DM_ADDR;
    logic [31:0] DM_WDATA;
    logic [3:0]  DM_BE;
    logic [31:0] DM_RDATA;
    logic        DM_ACK;
    logic [31:0] MEM_ALU_RES;
    logic [31:0] MEM_DM_Q;
    logic [1:0]  MEM_RF_D_SEL;
    logic        MEM_VALID;
    logic        MEM_MISALIGN;
    logic        MEM_BUS_ERR;
    logic        MEM_STALL;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .EX_VALID(EX_VALID), .EX_ALU_RES(EX_ALU_RES), .EX_RS2_DATA(EX_RS2_DATA),
        .EX_MEM_RD(EX_MEM_RD), .EX_MEM_WR(EX_MEM_WR), .EX_MEM_SIZE(EX_MEM_SIZE),
        .EX_MEM_UNSIGNED(EX_MEM_UNSIGNED), .EX_RF_D_SEL(EX_RF_D_SEL),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
        .DM_BE(DM_BE), .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK),
        .MEM_ALU_RES(MEM_ALU_RES), .MEM_DM_Q(MEM_DM_Q), .MEM_RF_D_SEL(MEM_RF_D_SEL),
        .MEM_VALID(MEM_VALID), .MEM_MISALIGN(MEM_MISALIGN), .MEM_BUS_ERR(MEM_BUS_ERR),
        .MEM_STALL(MEM_STALL)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] dmq;
        logic [1:0]  sel;
        logic        mis;
        logic        berr;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        int          delay;
    } req_t;

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [1:0]  sel;
        int          delay;
    } op_t;

    res_t        exp_q[$];
    req_t        req_q[$];
    op_t         op_q[$];
    logic [31:0] mem [16];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        exp_stall;
    int          req_age;
    logic        have_req;
    req_t        cur_req;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'b00) return 4'b0001 << off;
        if (size == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (size == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * off));
        h = off[1] ? w[31:16] : w[15:0];
        if (size == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
        if (size == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic f_misal(input logic [1:0] size, input logic [1:0] off);
        return ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
    endfunction

    task automatic add_op(input logic valid, input logic rd, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [1:0] sel, input int delay);
        op_t o;
        o.valid = valid; o.rd = rd; o.wr = wr; o.size = size; o.uns = uns;
        o.addr = addr; o.rs2 = rs2; o.sel = sel; o.delay = delay;
        op_q.push_back(o);
    endtask

    task automatic drive_op(input op_t o);
        res_t r;
        req_t q;
        logic [31:0] mask;
        EX_VALID = o.valid; EX_ALU_RES = o.addr; EX_RS2_DATA = o.rs2;
        EX_MEM_RD = o.rd; EX_MEM_WR = o.wr; EX_MEM_SIZE = o.size;
        EX_MEM_UNSIGNED = o.uns; EX_RF_D_SEL = o.sel;
        if (!o.valid) return;
        r.alu = o.addr; r.sel = o.sel; r.dmq = 32'h0; r.mis = 1'b0; r.berr = 1'b0;
        if ((o.rd || o.wr) && f_misal(o.size, o.addr[1:0])) begin
            r.mis = 1'b1;
        end else if (o.rd || o.wr) begin
            q.addr  = {o.addr[31:2], 2'b00};
            q.be    = f_be(o.size, o.addr[1:0]);
            q.wdata = f_wdata(o.size, o.rs2);
            q.we    = o.wr;
            q.delay = o.delay;
            req_q.push_back(q);
            exp_stall = 1'b1;
            if (o.delay == 0) r.berr = 1'b1;
            else if (o.rd) r.dmq = f_load(mem[o.addr[5:2]], o.size, o.addr[1:0], o.uns);
            if (o.wr && o.delay != 0) begin
                mask = {{8{q.be[3]}}, {8{q.be[2]}}, {8{q.be[1]}}, {8{q.be[0]}}};
                mem[o.addr[5:2]] = (mem[o.addr[5:2]] & ~mask) | (q.wdata & mask);
            end
        end
        exp_q.push_back(r);
    endtask

    task automatic cycle();
        res_t e;
        logic clear_stall;
        op_t  bub;
        @(negedge clk);
        if (MEM_VALID) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {31'h0, MEM_VALID}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("alu_res", MEM_ALU_RES, e.alu);
                chk("dm_q", MEM_DM_Q, e.dmq);
                chk("rf_d_sel", {30'h0, MEM_RF_D_SEL}, {30'h0, e.sel});
                chk("misalign", {31'h0, MEM_MISALIGN}, {31'h0, e.mis});
                chk("bus_err", {31'h0, MEM_BUS_ERR}, {31'h0, e.berr});
            end
        end else begin
            chk("flags_idle", {30'h0, MEM_MISALIGN, MEM_BUS_ERR}, 32'h0);
        end
        chk("stall", {31'h0, MEM_STALL}, {31'h0, exp_stall});
        chk("dm_req", {31'h0, DM_REQ}, {31'h0, exp_stall});
        clear_stall = 1'b0;
        if (DM_REQ) begin
            if (req_age == 0) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", {31'h0, DM_REQ}, 32'h0);
                    have_req = 1'b0;
                end else begin
                    cur_req  = req_q.pop_front();
                    have_req = 1'b1;
                end
            end
            if (have_req) begin
                chk("dm_addr", DM_ADDR, cur_req.addr);
                chk("dm_be", {28'h0, DM_BE}, {28'h0, cur_req.be});
                chk("dm_wdata", DM_WDATA, cur_req.wdata);
                chk("dm_we", {31'h0, DM_WE}, {31'h0, cur_req.we});
            end
            if (have_req && cur_req.delay != 0 && req_age == cur_req.delay - 1) begin
                DM_ACK = 1'b1;
                DM_RDATA = mem[cur_req.addr[5:2]];
                clear_stall = 1'b1;
                req_age = 0;
            end else begin
                DM_ACK = 1'b0;
                DM_RDATA = $urandom;
`ifdef LSU_TIMEOUT_EN
                if (have_req && cur_req.delay == 0 && req_age == TMO - 1) begin
                    clear_stall = 1'b1;
                    req_age = 0;
                end else begin
                    req_age++;
                end
`else
                req_age++;
`endif
            end
        end else begin
            DM_ACK   = 1'($urandom_range(0, 1));
            DM_RDATA = $urandom;
            req_age  = 0;
        end
        if (!exp_stall && op_q.size() > 0) begin
            drive_op(op_q.pop_front());
        end else begin
            bub.valid = 1'b0; bub.rd = 1'b0; bub.wr = 1'b0; bub.size = 2'b00; bub.uns = 1'b0;
            bub.addr = $urandom; bub.rs2 = $urandom; bub.sel = 2'b00; bub.delay = 1;
            drive_op(bub);
        end
        if (clear_stall) exp_stall = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((op_q.size() > 0 || exp_q.size() > 0 || exp_stall) && n < max_cycles) begin
            cycle();
            n++;
        end
        if (n >= max_cycles) chk("drain_budget", 32'(n), 32'(max_cycles - 1));
    endtask

    initial begin
        logic [1:0]  kind;
        logic [31:0] a;
        rst_n = 1'b0;
        EX_VALID = 1'b0; EX_ALU_RES = 32'h0; EX_RS2_DATA = 32'h0; EX_MEM_RD = 1'b0;
        EX_MEM_WR = 1'b0; EX_MEM_SIZE = 2'b00; EX_MEM_UNSIGNED = 1'b0; EX_RF_D_SEL = 2'b00;
        DM_RDATA = 32'h0; DM_ACK = 1'b0;
        exp_stall = 1'b0; req_age = 0; have_req = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'h80FFFFFF;
        repeat (3) @(negedge clk);
        chk("rst_dm_req", {31'h0, DM_REQ}, 32'h0);
        chk("rst_stall", {31'h0, MEM_STALL}, 32'h0);
        chk("rst_valid", {31'h0, MEM_VALID}, 32'h0);
        chk("rst_alu_res", MEM_ALU_RES, 32'h0);
        chk("rst_dm_q", MEM_DM_Q, 32'h0);
        chk("rst_flags", {29'h0, MEM_MISALIGN, MEM_BUS_ERR, DM_WE}, 32'h0);
        rst_n = 1'b1;

        add_op(1, 0, 0, 2'b00, 0, 32'h12345678, 32'h0, 2'b01, 1);
        add_op(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 2'b00, 1);
        add_op(1, 1, 0, 2'b00, 0, 32'h00000103, 32'h0, 2'b10, 3);
        add_op(1, 0, 1, 2'b01, 0, 32'h00000022, 32'hAAAABEEF, 2'b00, 2);
        add_op(1, 1, 0, 2'b10, 0, 32'h00000041, 32'h0, 2'b10, 1);
        add_op(1, 0, 1, 2'b01, 0, 32'h00000045, 32'h1234, 2'b00, 1);
        add_op(1, 1, 0, 2'b00, 1, 32'h00000103, 32'h0, 2'b10, 1);
        add_op(1, 1, 0, 2'b01, 0, 32'h00000022, 32'h0, 2'b10, 1);
        add_op(1, 1, 0, 2'b11, 0, 32'h00000020, 32'h0, 2'b10, 2);
        add_op(1, 0, 1, 2'b10, 0, 32'h00000030, 32'hDEADBEEF, 2'b00, 1);
        add_op(1, 0, 1, 2'b00, 0, 32'h00000031, 32'h12345677, 2'b00, 1);
        add_op(1, 1, 0, 2'b01, 1, 32'h00000030, 32'h0, 2'b11, 1);
        drain(500);

        // Abandon a load mid-access, then confirm a fresh load still completes.
        add_op(1, 1, 0, 2'b10, 0, 32'h00000034, 32'h0, 2'b01, 6);
        repeat (3) cycle();
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_dm_req", {31'h0, DM_REQ}, 32'h0);
        chk("rstmid_stall", {31'h0, MEM_STALL}, 32'h0);
        chk("rstmid_valid", {31'h0, MEM_VALID}, 32'h0);
        chk("rstmid_alu_res", MEM_ALU_RES, 32'h0);
        chk("rstmid_dm_addr", DM_ADDR, 32'h0);
        exp_q.delete(); req_q.delete();
        exp_stall = 1'b0; req_age = 0; have_req = 1'b0;
        EX_VALID = 1'b0; DM_ACK = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        add_op(1, 1, 0, 2'b00, 0, 32'h00000103, 32'h0, 2'b10, 2);
        drain(200);

        for (int i = 0; i < 60; i++) begin
            kind = 2'($urandom_range(0, 3));
            a = $urandom;
            add_op(kind != 2'd3, kind == 2'd1, kind == 2'd2, 2'($urandom), 1'($urandom),
                   a, $urandom, 2'($urandom), $urandom_range(1, 4));
        end
        drain(2000);

`ifdef LSU_TIMEOUT_EN
        add_op(1, 1, 0, 2'b10, 0, 32'h00000008, 32'h0, 2'b10, 0);
        add_op(1, 1, 0, 2'b10, 0, 32'h00000008, 32'h0, 2'b10, TMO);
        add_op(1, 0, 1, 2'b00, 0, 32'h00000009, 32'h55, 2'b00, 0);
        drain(200);
`endif

        chk("scoreboard_empty", 32'(exp_q.size() + req_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
